// File: rtl/dec.sv
// Decode stage: turns raw RV32I words into exm operands, tracks in-flight
// destination registers and stalls fetch on read-after-write hazards.
module dec (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        input_valid_i,
  output logic        input_ready_o,
  input  logic [31:0] pc_i,
  input  logic [31:0] instr_i,
  output logic [4:0]  rf_addr1_o,
  output logic [4:0]  rf_addr2_o,
  input  logic [31:0] rf_data1_i,
  input  logic [31:0] rf_data2_i,
  input  logic        wb_valid_i,
  input  logic [4:0]  wb_addr_i,
  input  logic        branch_i,
  input  logic        output_ready_i,
  output logic        output_valid_o,
  output logic [31:0] pc_o,
  output logic [31:0] instr_o,
  output logic [31:0] param1_o,
  output logic [31:0] param2_o,
  output logic [31:0] param3_o,
  output logic        illegal_o
);

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;

  // Immediate builders, all sign-extended to 32 bits
  function automatic logic signed [31:0] imm_i(input logic [31:0] ins);
    return {{20{ins[31]}}, ins[31:20]};
  endfunction

  function automatic logic signed [31:0] imm_s(input logic [31:0] ins);
    return {{20{ins[31]}}, ins[31:25], ins[11:7]};
  endfunction

  function automatic logic signed [31:0] imm_b(input logic [31:0] ins);
    return {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
  endfunction

  function automatic logic signed [31:0] imm_u(input logic [31:0] ins);
    return {ins[31:12], 12'b0};
  endfunction

  function automatic logic signed [31:0] imm_j(input logic [31:0] ins);
    return {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
  endfunction

  logic [6:0]         w_opcode;
  logic [4:0]         w_rs1;
  logic [4:0]         w_rs2;
  logic [4:0]         w_rd;
  logic               w_use_rs1;
  logic               w_use_rs2;
  logic               w_wr_rd;
  logic               w_illegal;
  logic signed [31:0] w_p1;
  logic signed [31:0] w_p2;
  logic signed [31:0] w_p3;
  logic [4:0]         w_rd_eff;
  logic               w_hazard;
  logic               w_stage_free;
  logic               w_accept;
  logic               w_leave;
  logic [31:0]        w_pending_nxt;

  logic               r_vld_p1;
  logic [31:0]        r_pc_p1;
  logic [31:0]        r_instr_p1;
  logic signed [31:0] r_param1_p1;
  logic signed [31:0] r_param2_p1;
  logic signed [31:0] r_param3_p1;
  logic               r_illegal_p1;
  logic [4:0]         r_rd_p1;
  logic [31:0]        r_pending;

  assign w_opcode   = instr_i[6:0];
  assign w_rs1      = instr_i[19:15];
  assign w_rs2      = instr_i[24:20];
  assign w_rd       = instr_i[11:7];
  assign rf_addr1_o = w_rs1;
  assign rf_addr2_o = w_rs2;

  // ---- stage p0: combinational decode of the incoming word ----

  // Classify the opcode: which sources it reads, whether it writes rd, and its operands
  always_comb begin
    w_use_rs1 = 1'b0;
    w_use_rs2 = 1'b0;
    w_wr_rd   = 1'b0;
    w_illegal = 1'b0;
    w_p1      = '0;
    w_p2      = '0;
    w_p3      = '0;
    unique case (w_opcode)
      OPC_OP: begin
        w_use_rs1 = 1'b1;
        w_use_rs2 = 1'b1;
        w_wr_rd   = 1'b1;
        w_p1      = rf_data1_i;
        w_p2      = rf_data2_i;
      end
      OPC_OP_IMM, OPC_LOAD, OPC_JALR: begin
        w_use_rs1 = 1'b1;
        w_wr_rd   = 1'b1;
        w_p1      = rf_data1_i;
        w_p2      = imm_i(instr_i);
      end
      OPC_STORE: begin
        w_use_rs1 = 1'b1;
        w_use_rs2 = 1'b1;
        w_p1      = rf_data1_i;
        w_p2      = imm_s(instr_i);
        w_p3      = rf_data2_i;
      end
      OPC_BRANCH: begin
        w_use_rs1 = 1'b1;
        w_use_rs2 = 1'b1;
        w_p1      = rf_data1_i;
        w_p2      = rf_data2_i;
        w_p3      = imm_b(instr_i);
      end
      OPC_LUI: begin
        w_wr_rd   = 1'b1;
        w_p2      = imm_u(instr_i);
      end
      OPC_AUIPC: begin
        w_wr_rd   = 1'b1;
        w_p1      = pc_i;
        w_p2      = imm_u(instr_i);
      end
      OPC_JAL: begin
        w_wr_rd   = 1'b1;
        w_p1      = pc_i;
        w_p2      = imm_j(instr_i);
      end
      default: begin
        w_illegal = 1'b1;
      end
    endcase
  end

  // rd as tracked by the scoreboard; x0 collapses to "no destination"
  assign w_rd_eff = (w_wr_rd && (w_rd != 5'd0)) ? w_rd : 5'd0;

  // A source is busy if pending and not being written back right now (write-first
  // register file), or if it is the destination of the word sitting in the output stage
  always_comb begin
    w_hazard = 1'b0;
    if (w_use_rs1 && (w_rs1 != 5'd0)) begin
      if ((r_pending[w_rs1] && !(wb_valid_i && (wb_addr_i == w_rs1))) ||
          (r_vld_p1 && (r_rd_p1 == w_rs1)))
        w_hazard = 1'b1;
    end
    if (w_use_rs2 && (w_rs2 != 5'd0)) begin
      if ((r_pending[w_rs2] && !(wb_valid_i && (wb_addr_i == w_rs2))) ||
          (r_vld_p1 && (r_rd_p1 == w_rs2)))
        w_hazard = 1'b1;
    end
  end

  assign w_stage_free  = !r_vld_p1 || output_ready_i;
  assign input_ready_o = w_stage_free && !w_hazard && !branch_i;
  assign w_accept      = input_valid_i && input_ready_o;
  assign w_leave       = r_vld_p1 && output_ready_i && !branch_i;

  // Scoreboard update: writeback clears first so a same-register issue wins
  always_comb begin
    w_pending_nxt = r_pending;
    if (wb_valid_i)
      w_pending_nxt[wb_addr_i] = 1'b0;
    if (w_leave && (r_rd_p1 != 5'd0))
      w_pending_nxt[r_rd_p1] = 1'b1;
    w_pending_nxt[0] = 1'b0;
  end

  // Pending-register vector
  always_ff @(posedge clk_i) begin
    if (!rst_i)
      r_pending <= '0;
    else
      r_pending <= w_pending_nxt;
  end

  // ---- stage p1: registered output toward exm ----

  // One-deep output register: flush, load on accept, drain on handshake, else hold
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      r_vld_p1     <= 1'b0;
      r_illegal_p1 <= 1'b0;
      r_pc_p1      <= '0;
      r_instr_p1   <= '0;
      r_param1_p1  <= '0;
      r_param2_p1  <= '0;
      r_param3_p1  <= '0;
      r_rd_p1      <= '0;
    end else if (branch_i) begin
      r_vld_p1     <= 1'b0;
      r_illegal_p1 <= 1'b0;
    end else if (w_accept) begin
      r_vld_p1     <= 1'b1;
      r_illegal_p1 <= w_illegal;
      r_pc_p1      <= pc_i;
      r_instr_p1   <= instr_i;
      r_param1_p1  <= w_p1;
      r_param2_p1  <= w_p2;
      r_param3_p1  <= w_p3;
      r_rd_p1      <= w_rd_eff;
    end else if (output_ready_i) begin
      r_vld_p1     <= 1'b0;
      r_illegal_p1 <= 1'b0;
    end
  end

  assign output_valid_o = r_vld_p1;
  assign pc_o           = r_pc_p1;
  assign instr_o        = r_instr_p1;
  assign param1_o       = r_param1_p1;
  assign param2_o       = r_param2_p1;
  assign param3_o       = r_param3_p1;
  assign illegal_o      = r_illegal_p1;

endmodule

// File: tb/tb_dec.sv
// Testbench for the decode stage: directed table, hand-written corner
// sequences, then randomized traffic against a behavioural model.
module tb_dec;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        in_valid = 1'b0;
  logic        ready;
  logic [31:0] pc = '0;
  logic [31:0] instr = '0;
  logic [4:0]  rfa1, rfa2;
  logic [31:0] rf1, rf2;
  logic        wb_valid = 1'b0;
  logic [4:0]  wb_addr = '0;
  logic        branch = 1'b0;
  logic        out_ready = 1'b0;
  logic        out_valid;
  logic [31:0] pco, instro, p1, p2, p3;
  logic        ill;

  logic [31:0] regs [32];
  assign rf1 = regs[rfa1];
  assign rf2 = regs[rfa2];

  dec dut (
    .clk_i(clk), .rst_i(rst),
    .input_valid_i(in_valid), .input_ready_o(ready),
    .pc_i(pc), .instr_i(instr),
    .rf_addr1_o(rfa1), .rf_addr2_o(rfa2),
    .rf_data1_i(rf1), .rf_data2_i(rf2),
    .wb_valid_i(wb_valid), .wb_addr_i(wb_addr),
    .branch_i(branch), .output_ready_i(out_ready),
    .output_valid_o(out_valid), .pc_o(pco), .instr_o(instro),
    .param1_o(p1), .param2_o(p2), .param3_o(p3), .illegal_o(ill)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  localparam logic [31:0] ADDI5  = 32'h00700293; // addi x5,x0,7
  localparam logic [31:0] SW     = 32'hFE612E23; // sw x6,-4(x2)
  localparam logic [31:0] LUI3   = 32'h123451B7; // lui x3,0x12345
  localparam logic [31:0] AUIPC4 = 32'h00001217; // auipc x4,1
  localparam logic [31:0] JAL1   = 32'h008000EF; // jal x1,8
  localparam logic [31:0] BEQ    = 32'hFE208CE3; // beq x1,x2,-8
  localparam logic [31:0] ADD7   = 32'h001283B3; // add x7,x5,x1
  localparam logic [31:0] LW8    = 32'h0101A403; // lw x8,16(x3)
  localparam logic [31:0] JALR0  = 32'h00008067; // jalr x0,0(x1)
  localparam logic [31:0] ILL    = 32'h0000007F; // unknown opcode
  localparam logic [31:0] ADDI9  = 32'hFFF10493; // addi x9,x2,-1

  typedef struct {
    logic [31:0] ins;
    logic [31:0] pc;
    logic [31:0] e1, e2, e3;
    logic        eill;
  } vec_t;

  vec_t tbl [11];

  // ---------------- behavioural reference model ----------------
  typedef struct {
    logic        use1, use2;
    logic [4:0]  rd;     // 0 when nothing is written
    logic [31:0] v1, v2, v3;
    logic        bad;
  } dref_t;

  function automatic dref_t ref_decode(input logic [31:0] ins, input logic [31:0] ipc);
    dref_t d;
    logic signed [31:0] s;
    logic [31:0] sg, hi20, hi25, iI, iS, iB, iU, iJ, r1, r2;
    logic [4:0] rdf;
    s    = $signed(ins);
    sg   = s >>> 31;
    hi20 = s >>> 20;
    hi25 = s >>> 25;
    iI = hi20;
    iS = (hi25 << 5) | ((ins >> 7) & 32'h1F);
    iB = (sg << 12) | (((ins >> 7) & 32'h1) << 11) | (((ins >> 25) & 32'h3F) << 5)
       | (((ins >> 8) & 32'hF) << 1);
    iU = ins & 32'hFFFFF000;
    iJ = (sg << 20) | (ins & 32'h000FF000) | (((ins >> 20) & 32'h1) << 11)
       | (((ins >> 21) & 32'h3FF) << 1);
    r1  = regs[ins[19:15]];
    r2  = regs[ins[24:20]];
    rdf = ins[11:7];
    d = '{use1: 1'b0, use2: 1'b0, rd: 5'd0, v1: 32'd0, v2: 32'd0, v3: 32'd0, bad: 1'b0};
    case (ins[6:0])
      7'h33: begin d.use1 = 1; d.use2 = 1; d.rd = rdf; d.v1 = r1; d.v2 = r2; end
      7'h13, 7'h03, 7'h67: begin d.use1 = 1; d.rd = rdf; d.v1 = r1; d.v2 = iI; end
      7'h23: begin d.use1 = 1; d.use2 = 1; d.v1 = r1; d.v2 = iS; d.v3 = r2; end
      7'h63: begin d.use1 = 1; d.use2 = 1; d.v1 = r1; d.v2 = r2; d.v3 = iB; end
      7'h37: begin d.rd = rdf; d.v2 = iU; end
      7'h17: begin d.rd = rdf; d.v1 = ipc; d.v2 = iU; end
      7'h6F: begin d.rd = rdf; d.v1 = ipc; d.v2 = iJ; end
      default: d.bad = 1;
    endcase
    return d;
  endfunction

  logic        m_vld, m_ill, m_acc;
  logic [31:0] m_pc, m_instr, m_p1, m_p2, m_p3;
  logic [4:0]  m_rd;
  bit          m_pend [32];

  task automatic model_reset();
    m_vld = 0; m_ill = 0; m_pc = 0; m_instr = 0; m_p1 = 0; m_p2 = 0; m_p3 = 0; m_rd = 0;
    m_acc = 0;
    for (int i = 0; i < 32; i++) m_pend[i] = 0;
  endtask

  function automatic bit src_blocked(input logic [4:0] a);
    if (a == 0) return 0;
    if (m_pend[a] && !(wb_valid && wb_addr == a)) return 1;
    return m_vld && (m_rd == a);
  endfunction

  function automatic logic model_ready();
    dref_t d;
    bit hz;
    d  = ref_decode(instr, pc);
    hz = (d.use1 && src_blocked(instr[19:15])) || (d.use2 && src_blocked(instr[24:20]));
    return (!m_vld || out_ready) && !hz && !branch;
  endfunction

  task automatic model_step();
    dref_t d;
    bit    rdy, retire;
    if (!rst) begin
      model_reset();
      return;
    end
    d      = ref_decode(instr, pc);
    rdy    = model_ready();
    m_acc  = in_valid && rdy;
    retire = m_vld && out_ready && !branch;
    if (wb_valid) m_pend[wb_addr] = 0;
    if (retire && m_rd != 0) m_pend[m_rd] = 1;
    if (branch) begin
      m_vld = 0; m_ill = 0;
    end else if (m_acc) begin
      m_vld = 1; m_ill = d.bad; m_pc = pc; m_instr = instr;
      m_p1 = d.v1; m_p2 = d.v2; m_p3 = d.v3; m_rd = d.rd;
    end else if (out_ready) begin
      m_vld = 0; m_ill = 0;
    end
  endtask

  // ---------------- helpers ----------------
  task automatic do_reset();
    @(negedge clk);
    rst = 0; in_valid = 0; branch = 0; wb_valid = 0;
    @(negedge clk);
    rst = 1;
  endtask

  logic [6:0] ops [11];

  initial begin
    for (int i = 0; i < 32; i++) regs[i] = 32'h101 * i;
    regs[1] = 32'h11111111;
    regs[2] = 32'h00002000;
    regs[6] = 32'h000000AB;

    tbl[0]  = '{ADDI5,  32'h100, 32'h0,        32'h7,        32'h0,        1'b0};
    tbl[1]  = '{SW,     32'h104, 32'h2000,     32'hFFFFFFFC, 32'hAB,       1'b0};
    tbl[2]  = '{LUI3,   32'h108, 32'h0,        32'h12345000, 32'h0,        1'b0};
    tbl[3]  = '{AUIPC4, 32'h200, 32'h200,      32'h1000,     32'h0,        1'b0};
    tbl[4]  = '{JAL1,   32'h300, 32'h300,      32'h8,        32'h0,        1'b0};
    tbl[5]  = '{BEQ,    32'h304, 32'h11111111, 32'h2000,     32'hFFFFFFF8, 1'b0};
    tbl[6]  = '{ADD7,   32'h308, 32'h505,      32'h11111111, 32'h0,        1'b0};
    tbl[7]  = '{LW8,    32'h30C, 32'h303,      32'h10,       32'h0,        1'b0};
    tbl[8]  = '{JALR0,  32'h310, 32'h11111111, 32'h0,        32'h0,        1'b0};
    tbl[9]  = '{ILL,    32'h314, 32'h0,        32'h0,        32'h0,        1'b1};
    tbl[10] = '{ADDI9,  32'h318, 32'h2000,     32'hFFFFFFFF, 32'h0,        1'b0};

    ops = '{7'h33, 7'h13, 7'h03, 7'h67, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F, 7'h7F, 7'h0B};

    // reset state
    repeat (2) @(negedge clk);
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_illegal", 32'(ill), 32'd0);
    chk("rst_pc", pco, 32'd0);
    chk("rst_instr", instro, 32'd0);
    chk("rst_p1", p1, 32'd0);
    chk("rst_p2", p2, 32'd0);
    chk("rst_p3", p3, 32'd0);
    rst = 1;

    // directed table, one instruction per fresh reset
    for (int i = 0; i < 11; i++) begin
      @(negedge clk);
      in_valid = 1; instr = tbl[i].ins; pc = tbl[i].pc; out_ready = 1;
      #1 chk("tbl_ready", 32'(ready), 32'd1);
      chk("tbl_rfa1", 32'(rfa1), 32'(tbl[i].ins[19:15]));
      chk("tbl_rfa2", 32'(rfa2), 32'(tbl[i].ins[24:20]));
      @(negedge clk);
      in_valid = 0;
      chk("tbl_valid", 32'(out_valid), 32'd1);
      chk("tbl_pc", pco, tbl[i].pc);
      chk("tbl_instr", instro, tbl[i].ins);
      chk("tbl_p1", p1, tbl[i].e1);
      chk("tbl_p2", p2, tbl[i].e2);
      chk("tbl_p3", p3, tbl[i].e3);
      chk("tbl_illegal", 32'(ill), 32'(tbl[i].eill));
      do_reset();
    end

    // RAW hazard released by writeback in the same cycle
    @(negedge clk);
    instr = ADDI5; pc = 32'h100; in_valid = 1; out_ready = 1;
    @(negedge clk);
    instr = ADD7; pc = 32'h104;
    #1 chk("hz_ready_outstage", 32'(ready), 32'd0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      #1 chk("hz_ready_pending", 32'(ready), 32'd0);
      chk("hz_valid_low", 32'(out_valid), 32'd0);
    end
    @(negedge clk);
    wb_valid = 1; wb_addr = 5'd5;
    #1 chk("hz_ready_wb", 32'(ready), 32'd1);
    @(negedge clk);
    wb_valid = 0; in_valid = 0;
    chk("hz_valid", 32'(out_valid), 32'd1);
    chk("hz_instr", instro, ADD7);
    chk("hz_p1", p1, 32'h505);
    do_reset();

    // backpressure holds the output stage
    @(negedge clk);
    instr = BEQ; pc = 32'h400; in_valid = 1; out_ready = 1;
    @(negedge clk);
    out_ready = 0; instr = ADDI9; pc = 32'h404;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("bp_valid", 32'(out_valid), 32'd1);
      chk("bp_pc", pco, 32'h400);
      chk("bp_p1", p1, 32'h11111111);
      chk("bp_p3", p3, 32'hFFFFFFF8);
      chk("bp_ready", 32'(ready), 32'd0);
      @(negedge clk);
    end
    out_ready = 1;
    #1 chk("bp_ready_release", 32'(ready), 32'd1);
    @(negedge clk);
    in_valid = 0;
    chk("bp_next_pc", pco, 32'h404);
    chk("bp_next_instr", instro, ADDI9);
    do_reset();

    // flush: output dropped and its rd never becomes pending
    @(negedge clk);
    instr = ADDI5; pc = 32'h500; in_valid = 1; out_ready = 1;
    @(negedge clk);
    branch = 1; instr = LUI3;
    #1 chk("fl_ready_blocked", 32'(ready), 32'd0);
    @(negedge clk);
    branch = 0;
    chk("fl_valid", 32'(out_valid), 32'd0);
    chk("fl_illegal", 32'(ill), 32'd0);
    instr = ADD7; pc = 32'h600;
    #1 chk("fl_no_pending", 32'(ready), 32'd1);
    @(negedge clk);
    in_valid = 0;
    chk("fl_next_valid", 32'(out_valid), 32'd1);
    chk("fl_next_instr", instro, ADD7);
    do_reset();

    // reset in the middle of a hazard stall
    @(negedge clk);
    instr = ADDI5; pc = 32'h700; in_valid = 1; out_ready = 1;
    @(negedge clk);
    instr = ADD7; pc = 32'h704;
    repeat (2) @(negedge clk);
    #1 chk("rs_stalled", 32'(ready), 32'd0);
    rst = 0;
    @(negedge clk);
    rst = 1;
    chk("rs_valid", 32'(out_valid), 32'd0);
    chk("rs_pc", pco, 32'd0);
    chk("rs_instr", instro, 32'd0);
    chk("rs_p1", p1, 32'd0);
    chk("rs_p2", p2, 32'd0);
    chk("rs_p3", p3, 32'd0);
    chk("rs_illegal", 32'(ill), 32'd0);
    #1 chk("rs_sb_empty", 32'(ready), 32'd1);
    @(negedge clk);
    in_valid = 0;
    chk("rs_accept", 32'(out_valid), 32'd1);
    chk("rs_accept_instr", instro, ADD7);
    do_reset();

    // randomized traffic against the model
    model_reset();
    for (int c = 0; c < 3000; c++) begin
      int q[$];
      @(negedge clk);
      chk("rnd_valid", 32'(out_valid), 32'(m_vld));
      if (m_vld) begin
        chk("rnd_pc", pco, m_pc);
        chk("rnd_instr", instro, m_instr);
        chk("rnd_p1", p1, m_p1);
        chk("rnd_p2", p2, m_p2);
        chk("rnd_p3", p3, m_p3);
        chk("rnd_illegal", 32'(ill), 32'(m_ill));
      end
      rst = ($urandom_range(0, 199) != 0);
      if (!(in_valid && !m_acc)) begin
        logic [31:0] w;
        w = $urandom;
        w[6:0]   = ops[$urandom_range(0, 10)];
        w[11:7]  = 5'($urandom_range(0, 7));
        w[19:15] = 5'($urandom_range(0, 7));
        w[24:20] = 5'($urandom_range(0, 7));
        instr    = w;
        pc       = $urandom & 32'hFFFFFFFC;
        in_valid = ($urandom_range(0, 9) < 8);
      end
      out_ready = ($urandom_range(0, 9) < 7);
      branch    = ($urandom_range(0, 19) == 0);
      for (int i = 1; i < 32; i++) if (m_pend[i]) q.push_back(i);
      if (q.size() > 0 && $urandom_range(0, 9) < 4) begin
        wb_valid = 1;
        wb_addr  = 5'(q[$urandom_range(0, q.size() - 1)]);
      end else begin
        wb_valid = ($urandom_range(0, 9) == 0);
        wb_addr  = 5'($urandom_range(0, 31));
      end
      #1;
      chk("rnd_ready", 32'(ready), 32'(model_ready()));
      chk("rnd_rfa1", 32'(rfa1), 32'(instr[19:15]));
      chk("rnd_rfa2", 32'(rfa2), 32'(instr[24:20]));
      model_step();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/dec.md
Name: dec

Overview:
Decode stage of the ECAP5-DPROC pipeline. It sits between the fetch stage and the execute/memory stage (exm).
- Accepts raw RV32I instruction words, reads operands from the register file and builds the immediates.
- Tracks in-flight destination registers in a scoreboard and stalls on RAW hazards.
- Presents pc/instr/param1..3 to exm through a one-deep registered valid/ready stage, flushed on taken branch.

Parameters:
none

Ports:
clk_i  in  1  clock, all logic on rising edge
rst_i  in  1  reset, synchronous, active-low
input_valid_i  in  1  fetch has an instruction
input_ready_o  out  1  decode accepts this cycle (combinational)
pc_i  in  32  pc of incoming instruction
instr_i  in  32  raw instruction word
rf_addr1_o  out  5  register file read address 1, = instr_i[19:15] (combinational)
rf_addr2_o  out  5  register file read address 2, = instr_i[24:20] (combinational)
rf_data1_i  in  32  read data 1, same cycle, write-first
rf_data2_i  in  32  read data 2, same cycle, write-first
wb_valid_i  in  1  writeback retires a register write
wb_addr_i  in  5  register being written back
branch_i  in  1  taken branch/jump from exm, flush
output_ready_i  in  1  exm ready
output_valid_o  out  1  decoded instruction valid
pc_o  out  32  registered pc
instr_o  out  32  registered raw instruction
param1_o  out  32  operand 1
param2_o  out  32  operand 2
param3_o  out  32  operand 3
illegal_o  out  1  unknown opcode flag, valid with output_valid_o

Behaviour:
- Reset (rst_i=0 at edge):
  - output_valid_o=0, illegal_o=0.
  - pc_o, instr_o, param1_o, param2_o, param3_o all 0.
  - Scoreboard cleared.
  - Reset mid-stall drops the held instruction.
- Output stage:
  - stage_free = !output_valid_o || output_ready_i.
  - input_ready_o = stage_free && !hazard && !branch_i.
  - Accept = input_valid_i && input_ready_o. On accept, all outputs load next edge and output_valid_o=1.
  - Latency from accept to valid is 1 cycle.
  - Output handshake without a new accept: output_valid_o=0.
  - While output_valid_o && !output_ready_i, all outputs hold stable.
- Operand formation (imm sign-extended to 32):
  - OP (0110011): p1=rs1, p2=rs2, p3=0.
  - OP-IMM (0010011), LOAD (0000011), JALR (1100111): p1=rs1, p2=I-imm, p3=0.
  - STORE (0100011): p1=rs1, p2=S-imm, p3=rs2.
  - BRANCH (1100011): p1=rs1, p2=rs2, p3=B-imm.
  - LUI (0110111): p1=0, p2=U-imm.
  - AUIPC (0010111): p1=pc_i, p2=U-imm.
  - JAL (1101111): p1=pc_i, p2=J-imm, p3=0.
  - Any other opcode: params 0, illegal_o=1. Still a valid output, not a stall.
- Register usage:
  - rs1 is used by all opcodes except LUI, AUIPC and JAL.
  - rs2 is used by OP, STORE and BRANCH only.
  - rd is written by all except STORE, BRANCH and illegal.
  - x0 is never pending and never set.
- Scoreboard:
  - 32-bit pending vector.
  - Set rd bit when the instruction leaves the output stage (output_valid_o && output_ready_i && writes rd && rd!=0).
  - Clear wb_addr_i bit on wb_valid_i.
  - Simultaneous set and clear of the same register: set wins.
- Hazard:
  - Hazard when any used rs (!=0) has a pending bit set, excluding wb_addr_i when wb_valid_i=1, since the register file is write-first.
  - Hazard is also raised when an used rs equals the rd of the instruction currently in the output stage while output_valid_o=1.
- Flush:
  - branch_i=1 forces output_valid_o=0 and illegal_o=0 next edge, and blocks accept that cycle.
  - The flushed instruction never sets its scoreboard bit.
  - Scoreboard bits already set remain; they are cleared by writeback.
  - branch_i and wb_valid_i in the same cycle: the clear still applies.
- input_valid_i=0: no accept, rf_addr outputs still follow instr_i.

Test Plan:
- addi x5,x0,7 (0x00700293), pc 0x100, exm ready -> next cycle valid=1, pc_o=0x100, p1=0, p2=7, p3=0, illegal_o=0.
- sw x6,-4(x2), x2=0x2000, x6=0xAB -> p1=0x2000, p2=0xFFFFFFFC, p3=0xAB.
- addi x5 issued, then add x7,x5,x1 presented -> input_ready_o=0 until wb_valid_i with wb_addr_i=5; accepted in that same cycle.
- output_ready_i=0 for 3 cycles with a valid beq -> pc_o/param outputs constant, input_ready_o=0, then one handshake.
- branch_i=1 while output_valid_o=1 -> output_valid_o=0 next cycle, rd bit of flushed instruction not set.
- Opcode 0x7F -> valid=1, illegal_o=1, params 0. Assert rst_i=0 during a hazard stall -> all outputs 0, scoreboard empty.
